// File: rtl/load_store_unit_pkg.sv
// Shared memory-stage types for the load/store unit: the access-size mask,
// the LSU state encoding and the alignment/mask helpers.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE     = 2'd0,
        MEM_HALFWORD = 2'd1,
        MEM_WORD     = 2'd2
    } memory_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } lsu_state_t;

    // Only the two low address bits matter for alignment.
    function automatic logic is_misaligned(logic [1:0] addr_lo, memory_mask_t mask);
        logic mis;
        mis = 1'b0;
        case (mask)
            MEM_HALFWORD: mis = addr_lo[0];
            MEM_WORD:     mis = (addr_lo != 2'b00);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic mask_supported(memory_mask_t mask);
        return (mask == MEM_BYTE) || (mask == MEM_HALFWORD) || (mask == MEM_WORD);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response handshake of the load/store unit.
interface load_store_unit_if;

    logic                              req_valid;
    logic                              req_ready;
    logic [31:0]                       req_addr;
    logic [31:0]                       req_wdata;
    logic                              req_we;
    load_store_unit_pkg::memory_mask_t req_mask;
    logic                              req_unsigned;
    logic                              resp_valid;
    logic                              resp_ready;
    logic [31:0]                       resp_rdata;
    logic                              resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_mask, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_mask, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of load data by access size; words pass through.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0]  data_in,
    input  memory_mask_t mask,
    input  logic         is_unsigned,
    output logic [31:0]  data_out
);

    // Fill above the access width with the sign bit unless unsigned.
    always_comb begin
        data_out = data_in;
        case (mask)
            MEM_BYTE:     data_out = {{24{data_in[7] & ~is_unsigned}}, data_in[7:0]};
            MEM_HALFWORD: data_out = {{16{data_in[15] & ~is_unsigned}}, data_in[15:0]};
            default:      data_out = data_in;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end of the data RAM: one request at a time, misaligned
// accesses optionally split into byte beats, registered response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic                ram_we,
    output logic [31:0]         ram_a,
    output logic [31:0]         ram_wd,
    output memory_mask_t        ram_mask,
    input  logic [31:0]         ram_rd
);

    lsu_state_t   state_q, state_d;
    logic [31:0]  addr_q, wdata_q, buf_q, buf_merged;
    logic         we_q, uns_q;
    memory_mask_t mask_q;
    logic [1:0]   beat_q;
    logic [31:0]  resp_rdata_q, ext_in, ext_out;
    logic         resp_err_q;
    logic         req_bad, req_mis, last_beat;

    assign req_mis   = is_misaligned(bus.req_addr[1:0], bus.req_mask);
    assign req_bad   = !mask_supported(bus.req_mask) || (!SPLIT_MISALIGNED && req_mis);
    assign last_beat = (mask_q == MEM_HALFWORD) ? (beat_q == 2'd1) : (beat_q == 2'd3);

    // Split loads assemble bytes in buf; the final beat's byte is merged
    // combinationally so extension happens in the same cycle as the last read.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{beat_q, 3'b000} +: 8] = ram_rd[7:0];
    end

    assign ext_in = (state_q == SPLIT) ? buf_merged : ram_rd;

    load_extend u_extend (
        .data_in     (ext_in),
        .mask        (mask_q),
        .is_unsigned (uns_q),
        .data_out    (ext_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and RAM drive, decoded from the current state.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_a    = '0;
        ram_wd   = '0;
        ram_mask = MEM_WORD;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad)      state_d = RESP;
                    else if (req_mis) state_d = SPLIT;
                    else              state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_a    = addr_q;
                ram_mask = mask_q;
                ram_wd   = wdata_q;
                ram_we   = we_q;
                state_d  = RESP;
            end
            SPLIT: begin
                ram_a    = addr_q + {30'b0, beat_q};
                ram_mask = MEM_BYTE;
                ram_wd   = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
                ram_we   = we_q;
                if (last_beat) state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, beat sequencing and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            mask_q       <= MEM_WORD;
            beat_q       <= '0;
            buf_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q       <= bus.req_addr;
                        wdata_q      <= bus.req_wdata;
                        we_q         <= bus.req_we;
                        uns_q        <= bus.req_unsigned;
                        mask_q       <= bus.req_mask;
                        beat_q       <= '0;
                        buf_q        <= '0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_bad;
                    end
                end
                ACCESS: begin
                    resp_rdata_q <= we_q ? '0 : ext_out;
                end
                SPLIT: begin
                    buf_q  <= buf_merged;
                    beat_q <= beat_q + 2'd1;
                    if (last_beat) resp_rdata_q <= we_q ? '0 : ext_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule
